// File: rtl/dot_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dot_seq_pkg
// Brief    : Shared encodings, FSM states and default sizes for the dot
//            sequence driver.
// Revision : 1.0  initial release
// ============================================================================
package dot_seq_pkg;

  localparam int DEFAULT_MEM_LENGTH         = 48;
  localparam int DEFAULT_MEM_ADDRESS_LENGTH = 6;
  localparam int DEFAULT_PRESCALE_WIDTH     = 16;
  localparam int LANE_WIDTH                 = 16;
  localparam int MASK_WIDTH                 = 3;

  typedef enum logic [1:0] {
    OP_WR_ROW = 2'd0,
    OP_WR_DOT = 2'd1,
    OP_WR_SEL = 2'd2,
    OP_NOP    = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_SCAN  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dot_sequence_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : dot_sequence_driver_if
// Brief    : Host command valid/ready port of the dot sequence driver.
// Revision : 1.0  initial release
// ============================================================================
interface dot_sequence_driver_if #(
  parameter int MEM_ADDRESS_LENGTH = 6
) ();

  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [1:0]                    cmd_op;
  logic [MEM_ADDRESS_LENGTH-1:0] cmd_addr;
  logic [2:0]                    cmd_mask;
  logic [15:0]                   cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_mask, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_mask, cmd_data,
    output cmd_ready
  );

endinterface
`default_nettype wire

// File: rtl/dot_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : dot_scan_counter
// Brief    : Step prescaler plus column/row wrap counters for the field scan.
// Revision : 1.0  initial release
// ============================================================================
module dot_scan_counter #(
  parameter int MEM_ADDRESS_LENGTH = 6,
  parameter int PRESCALE_WIDTH     = 16
) (
  input  wire logic                          clock,
  input  wire logic                          reset,
  input  wire logic                          clear,
  input  wire logic                          enable,
  input  wire logic [PRESCALE_WIDTH-1:0]     period,
  input  wire logic [MEM_ADDRESS_LENGTH:0]   row_limit,
  input  wire logic [MEM_ADDRESS_LENGTH:0]   col_limit,
  output logic      [MEM_ADDRESS_LENGTH-1:0] row,
  output logic      [MEM_ADDRESS_LENGTH-1:0] col,
  output logic                               step,
  output logic                               frame_last
);

  localparam int LIM_W = MEM_ADDRESS_LENGTH + 1;

  logic [PRESCALE_WIDTH-1:0]     r_prescale;
  logic [MEM_ADDRESS_LENGTH-1:0] r_row;
  logic [MEM_ADDRESS_LENGTH-1:0] r_col;
  logic                          w_col_last;
  logic                          w_row_last;

  // period and limits are pre-sanitised by the caller (period >= 1, limits >= 1)
  assign w_col_last = ({1'b0, r_col} == (col_limit - LIM_W'(1)));
  assign w_row_last = ({1'b0, r_row} == (row_limit - LIM_W'(1)));
  assign step       = enable & (r_prescale == (period - PRESCALE_WIDTH'(1)));
  assign frame_last = w_row_last & w_col_last;
  assign row        = r_row;
  assign col        = r_col;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prescale <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else if (clear) begin
      r_prescale <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else if (enable) begin
      if (step) begin
        r_prescale <= '0;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + MEM_ADDRESS_LENGTH'(1);
        end else begin
          r_col <= r_col + MEM_ADDRESS_LENGTH'(1);
        end
      end else begin
        r_prescale <= r_prescale + PRESCALE_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dot_sequence_driver.sv
`default_nettype none
// ============================================================================
// Module   : dot_sequence_driver
// Brief    : Host command to sequencer table writes, plus prescaled field scan
//            sampling the firing outputs into a registered motor drive.
//            Option macro DOT_DRIVER_ONESHOT_EN: stop after one frame.
// Revision : 1.0  initial release
// ============================================================================
module dot_sequence_driver
  import dot_seq_pkg::*;
#(
  parameter int MEM_LENGTH         = DEFAULT_MEM_LENGTH,
  parameter int MEM_ADDRESS_LENGTH = DEFAULT_MEM_ADDRESS_LENGTH,
  parameter int PRESCALE_WIDTH     = DEFAULT_PRESCALE_WIDTH
) (
  input  wire logic                          clock,
  input  wire logic                          reset,
  dot_sequence_driver_if.slave               cmd,
  input  wire logic                          run_enable,
  input  wire logic                          sel_mode,
  input  wire logic [MEM_ADDRESS_LENGTH-1:0] row_limit,
  input  wire logic [MEM_ADDRESS_LENGTH-1:0] col_limit,
  input  wire logic [PRESCALE_WIDTH-1:0]     step_period,
  output logic      [MASK_WIDTH-1:0]         mask_select,
  output logic      [MEM_ADDRESS_LENGTH-1:0] mem_address,
  output logic      [LANE_WIDTH-1:0]         mem_data,
  output logic                               mem_write_n,
  output logic      [LANE_WIDTH-1:0]         mem_dot_data,
  output logic                               mem_dot_write_n,
  output logic      [MEM_ADDRESS_LENGTH-1:0] mem_sel_col_address,
  output logic      [MEM_ADDRESS_LENGTH-1:0] mem_sel_data,
  output logic                               mem_sel_write_n,
  output logic      [MEM_ADDRESS_LENGTH-1:0] row_select,
  output logic      [MEM_ADDRESS_LENGTH-1:0] col_select,
  output logic                               row_col_select,
  input  wire logic                          firing_data,
  input  wire logic                          firing_bit,
  output logic                               drive_out,
  output logic                               drive_valid,
  output logic                               frame_done,
  output logic                               scan_busy
);

  localparam int LIM_W = MEM_ADDRESS_LENGTH + 1;

  state_e                    r_state;
  state_e                    w_state_next;
  cmd_op_e                   w_op;
  logic                      w_accept;
  logic                      w_start;
  logic                      w_start_ok;
  logic                      w_oneshot_stop;
  logic                      w_step;
  logic                      w_frame_last;
  logic [LIM_W-1:0]          r_row_lim;
  logic [LIM_W-1:0]          r_col_lim;
  logic [PRESCALE_WIDTH-1:0] r_period;

  function automatic logic [LIM_W-1:0] clamp_limit(input logic [MEM_ADDRESS_LENGTH-1:0] v);
    if ((v == '0) || ({1'b0, v} > LIM_W'(MEM_LENGTH)))
      return LIM_W'(MEM_LENGTH);
    return {1'b0, v};
  endfunction

  assign w_op          = cmd_op_e'(cmd.cmd_op);
  assign cmd.cmd_ready = (r_state == ST_IDLE) & ~run_enable;
  assign w_accept      = cmd.cmd_valid & cmd.cmd_ready;
  assign w_start       = (r_state == ST_IDLE) & run_enable & w_start_ok;
  assign scan_busy     = (r_state == ST_SCAN);

`ifdef DOT_DRIVER_ONESHOT_EN
  logic r_armed;

  // Re-armed only by seeing run_enable low, so a held run gives exactly one frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_armed <= 1'b1;
    else if (!run_enable)
      r_armed <= 1'b1;
    else if (w_step && w_frame_last)
      r_armed <= 1'b0;
  end

  assign w_start_ok     = r_armed;
  assign w_oneshot_stop = w_frame_last;
`else
  assign w_start_ok     = 1'b1;
  assign w_oneshot_stop = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start)
          w_state_next = ST_SCAN;
        else if (w_accept && (w_op != OP_NOP))
          w_state_next = ST_WRITE;
      end
      ST_WRITE: w_state_next = ST_IDLE;
      ST_SCAN: begin
        if (w_step && (!run_enable || w_oneshot_stop))
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Buses are loaded on accept so they are already stable during the strobe cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask_select         <= '0;
      mem_address         <= '0;
      mem_data            <= '0;
      mem_write_n         <= 1'b1;
      mem_dot_data        <= '0;
      mem_dot_write_n     <= 1'b1;
      mem_sel_col_address <= '0;
      mem_sel_data        <= '0;
      mem_sel_write_n     <= 1'b1;
    end else begin
      mem_write_n     <= 1'b1;
      mem_dot_write_n <= 1'b1;
      mem_sel_write_n <= 1'b1;
      if (w_accept) begin
        case (w_op)
          OP_WR_ROW: begin
            mem_address <= cmd.cmd_addr;
            mask_select <= cmd.cmd_mask;
            mem_data    <= cmd.cmd_data;
            mem_write_n <= 1'b0;
          end
          OP_WR_DOT: begin
            mask_select     <= cmd.cmd_mask;
            mem_dot_data    <= cmd.cmd_data;
            mem_dot_write_n <= 1'b0;
          end
          OP_WR_SEL: begin
            mem_sel_col_address <= cmd.cmd_addr;
            mem_sel_data        <= cmd.cmd_data[MEM_ADDRESS_LENGTH-1:0];
            mem_sel_write_n     <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_row_lim      <= '0;
      r_col_lim      <= '0;
      r_period       <= '0;
      row_col_select <= 1'b0;
    end else if (w_start) begin
      r_row_lim      <= clamp_limit(row_limit);
      r_col_lim      <= clamp_limit(col_limit);
      r_period       <= (step_period == '0) ? PRESCALE_WIDTH'(1) : step_period;
      row_col_select <= sel_mode;
    end
  end

  dot_scan_counter #(
    .MEM_ADDRESS_LENGTH (MEM_ADDRESS_LENGTH),
    .PRESCALE_WIDTH     (PRESCALE_WIDTH)
  ) u_scan_counter (
    .clock      (clock),
    .reset      (reset),
    .clear      (w_start),
    .enable     (scan_busy),
    .period     (r_period),
    .row_limit  (r_row_lim),
    .col_limit  (r_col_lim),
    .row        (row_select),
    .col        (col_select),
    .step       (w_step),
    .frame_last (w_frame_last)
  );

  // Firing inputs respond combinationally to the current selects, so sample on the step cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drive_out   <= 1'b0;
      drive_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      drive_valid <= w_step;
      frame_done  <= w_step & w_frame_last;
      if (w_step)
        drive_out <= firing_data & firing_bit;
    end
  end

endmodule
`default_nettype wire
